// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared CPU package: CSR numbers plus the flush/redirect controller's state
// encoding and flush-source priority order.
package flush_redirect_ctrl_pkg;

    localparam logic [13:0] CSR_CRMD = 14'h000;
    localparam logic [13:0] CSR_ASID = 14'h018;
    localparam logic [13:0] CSR_DMW0 = 14'h180;
    localparam logic [13:0] CSR_DMW1 = 14'h181;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DRAIN    = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    typedef enum logic [1:0] {
        StIdle     = ST_IDLE,
        StDrain    = ST_DRAIN,
        StRedirect = ST_REDIRECT
    } flush_state_e;

    // Lower index wins when several flush sources fire together.
    localparam int unsigned PRIO_EXC      = 0;
    localparam int unsigned PRIO_ERTN     = 1;
    localparam int unsigned PRIO_TLB      = 2;
    localparam int unsigned NUM_FLUSH_SRC = 3;

    localparam logic [1:0] OUTSTANDING_MAX = 2'd3;

endpackage

// File: rtl/fetch_outstanding_cnt.sv
// Saturating 2-bit count of instruction fetches accepted but not yet answered.
module fetch_outstanding_cnt
    import flush_redirect_ctrl_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [1:0] cnt_next_o
);

    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != OUTSTANDING_MAX) begin
            cnt_d = cnt_q + 2'd1;
        end else if (dec_i && !inc_i && cnt_q != 2'd0) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_next_o = cnt_d;

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(inc_i && !dec_i && cnt_q == OUTSTANDING_MAX))
        else $error("fetch_outstanding_cnt: increment at maximum");
    a_no_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(dec_i && !inc_i && cnt_q == 2'd0))
        else $error("fetch_outstanding_cnt: decrement at zero");
`endif

endmodule

// File: rtl/flush_redirect_ctrl.sv
// Pipeline flush controller: cancels the pipe, drains in-flight fetches, then
// hands the winning redirect target to IF.
module flush_redirect_ctrl
    import flush_redirect_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_exc_valid_i,
    input  logic [31:0] ex_entry_i,
    input  logic        ertn_flush_i,
    input  logic [31:0] era_i,
    input  logic        tlb_flush_i,
    input  logic [31:0] tlb_flush_addr_i,
    input  logic        if_req_accept_i,
    input  logic        if_data_ok_i,
    input  logic        if_redirect_ready_i,
    output logic        pipe_cancel_o,
    output logic        drop_resp_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    flush_state_e state_q, state_d;
    logic [31:0]  target_q, target_d;
    logic [1:0]   cnt_next;

    logic [NUM_FLUSH_SRC-1:0] src_valid;
    logic [31:0]              src_target [NUM_FLUSH_SRC];
    logic [31:0]              win_target;

    fetch_outstanding_cnt u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .inc_i      (if_req_accept_i),
        .dec_i      (if_data_ok_i),
        .cnt_next_o (cnt_next)
    );

    always_comb begin
        src_valid               = '0;
        src_valid[PRIO_EXC]     = wb_exc_valid_i;
        src_valid[PRIO_ERTN]    = ertn_flush_i;
        src_valid[PRIO_TLB]     = tlb_flush_i;
        src_target[PRIO_EXC]    = ex_entry_i;
        src_target[PRIO_ERTN]   = era_i;
        src_target[PRIO_TLB]    = tlb_flush_addr_i;
        win_target              = 32'd0;
        // Scan from lowest priority upward so the highest-priority source lands last.
        for (int i = NUM_FLUSH_SRC - 1; i >= 0; i--) begin
            if (src_valid[i]) begin
                win_target = src_target[i];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        target_d         = target_q;
        pipe_cancel_o    = 1'b0;
        drop_resp_o      = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = 32'd0;
        unique case (state_q)
            StIdle: begin
                // Gate with reset so the combinational response also reads 0 in reset.
                if (|src_valid && !rst_i) begin
                    pipe_cancel_o = 1'b1;
                    drop_resp_o   = 1'b1;
                    target_d      = win_target;
                    state_d       = (cnt_next == 2'd0) ? StRedirect : StDrain;
                end
            end
            StDrain: begin
                pipe_cancel_o = 1'b1;
                drop_resp_o   = 1'b1;
                if (cnt_next == 2'd0) begin
                    state_d = StRedirect;
                end
            end
            StRedirect: begin
                pipe_cancel_o    = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = target_q;
                if (if_redirect_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Scoreboard bench for flush_redirect_ctrl: driver feeds a flush/fetch model,
// monitor compares outputs and redirect targets against the queued predictions.
module tb_flush_redirect_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        wb_exc_valid_i = 1'b0;
    logic [31:0] ex_entry_i = '0;
    logic        ertn_flush_i = 1'b0;
    logic [31:0] era_i = '0;
    logic        tlb_flush_i = 1'b0;
    logic [31:0] tlb_flush_addr_i = '0;
    logic        if_req_accept_i = 1'b0;
    logic        if_data_ok_i = 1'b0;
    logic        if_redirect_ready_i = 1'b0;
    logic        pipe_cancel_o, drop_resp_o, redirect_valid_o, busy_o;
    logic [31:0] redirect_pc_o;

    flush_redirect_ctrl dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .wb_exc_valid_i      (wb_exc_valid_i),
        .ex_entry_i          (ex_entry_i),
        .ertn_flush_i        (ertn_flush_i),
        .era_i               (era_i),
        .tlb_flush_i         (tlb_flush_i),
        .tlb_flush_addr_i    (tlb_flush_addr_i),
        .if_req_accept_i     (if_req_accept_i),
        .if_data_ok_i        (if_data_ok_i),
        .if_redirect_ready_i (if_redirect_ready_i),
        .pipe_cancel_o       (pipe_cancel_o),
        .drop_resp_o         (drop_resp_o),
        .redirect_valid_o    (redirect_valid_o),
        .redirect_pc_o       (redirect_pc_o),
        .busy_o              (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        cancel;
        logic        drop;
        logic        valid;
        logic        busy;
        logic [31:0] pc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] tgt_q [$];
    int          checks = 0;
    int          errors = 0;

    // Reference model: a flush is pending from the event until the redirect
    // handshake; the redirect is offered once no fetch is outstanding.
    int unsigned model_out = 0;
    bit          model_flushing = 0;
    bit          model_drained = 0;
    logic [31:0] model_tgt = '0;

    task automatic cyc(input logic e, input logic r, input logic t, input logic a,
                       input logic d, input logic y, input logic [31:0] xe,
                       input logic [31:0] xr, input logic [31:0] xt);
        exp_t        ex;
        int unsigned after;
        @(posedge clk_i);
        #1;
        wb_exc_valid_i      = e;
        ertn_flush_i        = r;
        tlb_flush_i         = t;
        if_req_accept_i     = a;
        if_data_ok_i        = d;
        if_redirect_ready_i = y;
        ex_entry_i          = xe;
        era_i               = xr;
        tlb_flush_addr_i    = xt;
        after = model_out;
        if (a && !d) after = after + 1;
        if (d && !a) after = after - 1;
        ex = '0;
        if (!model_flushing) begin
            if (e || r || t) begin
                ex.cancel = 1'b1;
                ex.drop   = 1'b1;
                model_tgt = e ? xe : (r ? xr : xt);
                tgt_q.push_back(model_tgt);
                model_flushing = 1;
                model_drained  = (after == 0);
            end
        end else if (!model_drained) begin
            ex.cancel = 1'b1;
            ex.drop   = 1'b1;
            ex.busy   = 1'b1;
            model_drained = (after == 0);
        end else begin
            ex.cancel = 1'b1;
            ex.valid  = 1'b1;
            ex.busy   = 1'b1;
            ex.pc     = model_tgt;
            if (y) model_flushing = 0;
        end
        exp_q.push_back(ex);
        model_out = after;
    endtask

    task automatic idle(input logic y);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, y, 32'd0, 32'd0, 32'd0);
    endtask

    // Monitor: reset-time zero checks, per-cycle output checks, redirect targets.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i or posedge rst_i);
            if (rst_i) begin
                #1;
                checks++;
                if ({pipe_cancel_o, drop_resp_o, redirect_valid_o, busy_o, redirect_pc_o} != '0) begin
                    errors++;
                    $display("FAIL reset_outputs got cancel=%0b drop=%0b valid=%0b busy=%0b pc=%h want all 0",
                             pipe_cancel_o, drop_resp_o, redirect_valid_o, busy_o, redirect_pc_o);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({pipe_cancel_o, drop_resp_o, redirect_valid_o, busy_o, redirect_pc_o} != e) begin
                    errors++;
                    $display("FAIL cycle_outputs t=%0t got cancel=%0b drop=%0b valid=%0b busy=%0b pc=%h want cancel=%0b drop=%0b valid=%0b busy=%0b pc=%h",
                             $time, pipe_cancel_o, drop_resp_o, redirect_valid_o, busy_o, redirect_pc_o,
                             e.cancel, e.drop, e.valid, e.busy, e.pc);
                end
                if (redirect_valid_o && if_redirect_ready_i) begin
                    checks++;
                    if (tgt_q.size() == 0) begin
                        errors++;
                        $display("FAIL redirect_target t=%0t got pc=%h want no redirect", $time, redirect_pc_o);
                    end else if (redirect_pc_o != tgt_q[0]) begin
                        errors++;
                        $display("FAIL redirect_target t=%0t got pc=%h want %h", $time, redirect_pc_o, tgt_q[0]);
                        void'(tgt_q.pop_front());
                    end else begin
                        void'(tgt_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic        e, r, t, a, d, y;
        logic [31:0] xe, xr, xt;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;

        // Exception with nothing outstanding: redirect next cycle, idle after handshake.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C00_8000, 32'd0, 32'd0);
        idle(1'b1);
        idle(1'b0);

        // Drain of two outstanding fetches.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h1C00_0104);
        idle(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
        idle(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0);
        idle(1'b1);
        idle(1'b0);

        // Simultaneous events: exception wins, then ertn beats tlb_flush.
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA000_0040, 32'hB000_0080, 32'hC000_00C0);
        idle(1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA000_0040, 32'hB000_0080, 32'hC000_00C0);
        idle(1'b1);

        // Backpressure: new events while waiting on ready are ignored.
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_1234);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD_0000 + i, 32'h5555_0000, 32'd0);
        end
        idle(1'b1);
        idle(1'b0);

        // Accept and data_ok together while draining keeps the count at one.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'h1C00_2000, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
        idle(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0);
        idle(1'b1);
        idle(1'b0);

        // Reset in the middle of a drain, with an event held during reset.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0BAD_0000, 32'd0, 32'd0);
        idle(1'b0);
        @(posedge clk_i);
        #2;
        wb_exc_valid_i  = 1'b1;
        ex_entry_i      = 32'hFFFF_FFF0;
        if_req_accept_i = 1'b0;
        rst_i           = 1'b1;
        exp_q.delete();
        tgt_q.delete();
        model_out = 0;
        model_flushing = 0;
        model_drained = 0;
        @(posedge clk_i);
        #3;
        rst_i          = 1'b0;
        wb_exc_valid_i = 1'b0;
        // Counter must be back at zero: event redirects on the following cycle.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1C00_3000, 32'd0, 32'd0);
        idle(1'b1);
        idle(1'b0);

        // Randomized traffic that respects the fetch protocol.
        for (int n = 0; n < 1500; n++) begin
            e  = ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 11) == 0);
            t  = ($urandom_range(0, 9) == 0);
            a  = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 2) == 0);
            y  = ($urandom_range(0, 1) == 0);
            xe = $urandom;
            xr = $urandom;
            xt = $urandom;
            if (a && !d && model_out == 3) a = 1'b0;
            if (d && !a && model_out == 0) d = 1'b0;
            cyc(e, r, t, a, d, y, xe, xr, xt);
        end

        for (int n = 0; n < 10; n++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, model_out != 0, 1'b1, 32'd0, 32'd0, 32'd0);
        end
        @(negedge clk_i);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flush_redirect_ctrl.md
FLUSH_REDIRECT_CTRL -- requirements
Module: flush_redirect_ctrl

Interface
REQ-001 SHALL have one clock and one reset: clock clk; reset is asynchronous and active-high.
REQ-002 SHALL have ports: clk input 1, clock; reset input 1, async active-high reset.
REQ-003 SHALL have ports: wb_exc_valid input 1, WB exception; ex_entry input 32, exception entry from CSR.
REQ-004 SHALL have ports: ertn_flush input 1, WB ertn; era input 32, CSR ERA.
REQ-005 SHALL have ports: tlb_flush input 1, WB refetch request; tlb_flush_addr input 32, WB pc+4.
REQ-006 SHALL have ports: if_req_accept input 1, inst-sram req&addr_ok; if_data_ok input 1, inst-sram response.
REQ-007 SHALL have ports: if_redirect_ready input 1, IF accepts new pc.
REQ-008 SHALL have outputs: pipe_cancel 1, cancel all stages; drop_resp 1, IF discards current data_ok; redirect_valid 1; redirect_pc 32; busy 1, state != IDLE.

Function
REQ-009 SHALL implement states IDLE, DRAIN, REDIRECT; reset state IDLE.
REQ-010 SHALL, in IDLE with any event, assert pipe_cancel combinationally in the same cycle T.
REQ-011 SHALL hold pipe_cancel=1 in DRAIN and REDIRECT.
REQ-012 SHALL resolve simultaneous events with priority: exception (target ex_entry) > ertn (target era) > tlb_flush (target tlb_flush_addr).
REQ-013 SHALL latch the winning target at edge T into target_pc; events outside IDLE are ignored.
REQ-014 SHALL maintain a 2-bit outstanding-fetch counter in every state: +1 on if_req_accept only; -1 on if_data_ok only; unchanged on both or neither; range 0..3.
REQ-015 SHALL, at edge T, go to REDIRECT if the counter after its T update is 0, else to DRAIN.
REQ-016 SHALL assert drop_resp=1 in DRAIN and in cycle T.
REQ-017 SHALL, in DRAIN, move to REDIRECT on the edge where the counter reaches 0 (count==1, data_ok=1, req_accept=0).
REQ-018 SHALL, in REDIRECT, drive redirect_valid=1 and redirect_pc=target_pc, stable until handshake.
REQ-019 SHALL return to IDLE on the edge where redirect_valid&if_redirect_ready.
REQ-020 SHALL drive redirect_pc=0 when redirect_valid=0.
REQ-021 SHALL treat a counter increment at 3 and a decrement at 0 as protocol errors (simulation assertion); the counter saturates and does not wrap.

Reset
REQ-022 SHALL, on reset assertion, immediately go to state IDLE, counter 0, target_pc 0, with all outputs 0, including mid-DRAIN or mid-REDIRECT.
REQ-023 SHALL process the first event normally in the first cycle after reset deassertion.

Structure
REQ-024 SHALL place the state encoding (2-bit localparams) and the priority constants in the shared CPU package, alongside CSR_CRMD/ASID/DMW numbers.
REQ-025 SHALL be a single module; the outstanding counter is natural as sub-module fetch_outstanding_cnt.

Verification
REQ-026 SHALL cover an exception with 0 outstanding: wb_exc_valid, ex_entry=0x1C00_8000 at T -> pipe_cancel at T; redirect_valid at T+1 with pc 0x1C00_8000; ready at T+1 -> IDLE at T+2.
REQ-027 SHALL cover a drain of 2: counter=2, tlb_flush addr 0x1C00_0104 -> DRAIN, drop_resp high; data_ok at T+2,T+4 -> REDIRECT at T+5, pc 0x1C00_0104.
REQ-028 SHALL cover simultaneous events: exc+ertn+tlb_flush in one cycle -> redirect_pc=ex_entry; ertn+tlb_flush -> era.
REQ-029 SHALL cover backpressure: if_redirect_ready low 3 cycles -> redirect_valid/pc stable; new events ignored; IDLE one cycle after ready.
REQ-030 SHALL cover simultaneous counting: counter=1, req_accept and data_ok same cycle in DRAIN -> counter stays 1, no REDIRECT.
REQ-031 SHALL cover reset mid-DRAIN: reset pulsed -> outputs 0 asynchronously, busy=0, counter 0.
